otter_branch_predictor: RTL and testbench
=========================================

# otter_branch_predictor

Parametrised dynamic branch predictor for the pipelined Otter core. It pairs a direct-mapped BTB with a bimodal saturating-counter table, so taken branches and jumps redirect in F instead of costing a two-instruction flush when they resolve in E. Lookup is indexed by PCF and returns a prediction the same cycle. The table is trained from E-stage resolution, and the block reports mispredicts to the hazard unit, along with the corrected PC.

## Interface
Parameters:
- ENTRIES, 64, table depth; power of two, at least 4; IDX = log2(ENTRIES)
- TAG_BITS, 8, partial tag width taken from the PC above the index
- CTR_BITS, 2, saturating counter width, at least 1
- XLEN, 32, address width

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- PCF  in  XLEN  fetch PC
- PredTakenF  out  1  predict taken for PCF
- PredTargetF  out  XLEN  predicted target; equals PCF+4 when not taken
- PCE  in  XLEN  PC of the E-stage instruction
- PCPlus4E  in  XLEN  PCE+4
- BranchE  in  1  E instruction is a conditional branch
- JumpE  in  1  E instruction is JAL or JALR
- JalrE  in  1  E jump is JALR (qualifies JumpE)
- TakenE  in  1  actual outcome; ignored unless BranchE or JumpE
- TargetE  in  XLEN  actual target (PCTargetE or JALR result)
- PredTakenE, PredTargetE  in  1, XLEN  F prediction carried down the pipe
- StallE  in  1  E holds; suppresses training and counting
- MispredictE  out  1  flush D/E and redirect
- RedirectPCE  out  XLEN  correct next PC
- BranchCount, MispredictCount  out  32  saturating performance counters

## Operation
- Index = PC[IDX+1:2]. Tag = PC[IDX+1+TAG_BITS:IDX+2].
- Each entry holds valid, tag, target[XLEN-1:2] and ctr[CTR_BITS-1:0].
- Hit = valid && the tag matches.
- PredTakenF = hit && ctr MSB set. PredTargetF = PredTakenF ? {target,2'b00} : PCF+4.
- ActualTaken = (BranchE && TakenE) || JumpE.
- MispredictE:
  - If BranchE or JumpE: ActualTaken != PredTakenE, or (ActualTaken && PredTargetE != TargetE).
  - Otherwise: PredTakenE (alias on a non-control instruction).
  - Forced 0 while StallE or RST.
- RedirectPCE = ActualTaken ? TargetE : PCPlus4E.
- Training happens once per resolved instruction, only when !StallE and (BranchE or JumpE), at the index and tag of PCE:
  - Conditional hit: ctr increments on taken and decrements on not-taken, saturating at 0 and at 2^CTR_BITS-1. On taken, target is rewritten with TargetE.
  - Conditional miss, taken: allocate (overwriting whatever is there). Set valid, tag, target, and ctr = 2^(CTR_BITS-1) (weakly taken).
  - Conditional miss, not-taken: no write.
  - JAL hit or miss: allocate or overwrite with ctr = all ones.
  - JALR: no table write; MispredictE still evaluated.
  - Non-control instructions never write.
- Counters, when !StallE:
  - BranchCount increments on BranchE || JumpE.
  - MispredictCount increments on MispredictE.
  - Both saturate at 32'hFFFF_FFFF.
- Reset clears every valid bit, sets every ctr to 2^(CTR_BITS-1)-1 (weakly not-taken), and zeroes both counters. Target and tag contents are don't-care.

## Timing
- Lookup is combinational from PCF and table state; zero latency.
- Training writes at the rising CLK edge. Lookups see the new state from the next cycle.
- No write-to-read bypass: a same-cycle lookup of the index being trained returns the old contents.
- MispredictE and RedirectPCE are combinational from E inputs.
- Redirect PC is valid in the same cycle that MispredictE is high.
- Counter outputs are registered and update one edge after the event.
- RST asserted mid-operation takes effect at the next edge. It overrides any training in that cycle.
- During RST, PredTakenF = 0 (all entries invalid after the first edge).
- Reset values: PredTakenF=0, PredTargetF=PCF+4, BranchCount=0, MispredictCount=0.

## Structure
- Shared package otter_bp_pkg holds:
  - entry struct typedef (valid, tag, target, ctr)
  - CTR_WEAK_T / CTR_WEAK_NT constant functions of CTR_BITS
  - index and tag extraction functions
- Sub-module otter_sat_ctr: a CTR_BITS-wide saturating up/down next-value function block, instantiated once in the training path.
- Table is a register array (no BRAM) so that lookup can be asynchronous.

## Test plan
- Reset, then PCF=0x100 → PredTakenF=0, PredTargetF=0x104, counters 0.
- Branch at PCE=0x100, TakenE=1, TargetE=0x80, PredTakenE=0 → MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 gives PredTakenF=1, PredTargetF=0x80.
- Train 0x100 not-taken three times (CTR_BITS=2) → ctr 2→1→0→0. Predicts not-taken after the first, then saturates. MispredictCount increments only on the first.
- PCF=0x100+ENTRIES*4 (same index, different tag) after 0x100 is trained → PredTakenF=0. Training a taken branch there overwrites the entry, and 0x100 then misses.
- JALR at 0x200, TargetE=0x300, PredTakenE=0 → MispredictE=1, RedirectPCE=0x300; a later lookup of 0x200 still misses.
- Train 0x100 and look up 0x100 in the same cycle → old prediction returned. RST asserted alongside a training event → after the edge every lookup misses and both counters are 0.

Source files
------------

// File: rtl/otter_bp_pkg.sv
// Shared types and helpers for the Otter branch predictor.
// Entry fields are sized for the widest supported configuration
// (TAG_BITS <= 16, XLEN <= 64, CTR_BITS <= 8). Narrower instances zero-extend
// into them, so their upper bits stay constant.
package otter_bp_pkg;

  localparam int unsigned BP_TAG_MAX = 16;
  localparam int unsigned BP_TGT_MAX = 62;
  localparam int unsigned BP_CTR_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_MAX-1:0] tag;
    logic [BP_TGT_MAX-1:0] target;  // target PC[XLEN-1:2]
    logic [BP_CTR_MAX-1:0] ctr;
  } bp_entry_t;

  // Weakly-taken counter value: MSB set, all other bits clear.
  function automatic int unsigned ctr_weak_t(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Weakly-not-taken counter value: MSB clear, all other bits set.
  function automatic int unsigned ctr_weak_nt(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

  function automatic logic [63:0] bp_index(input logic [63:0] pc,
                                           input int unsigned idx_bits);
    return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc,
                                         input int unsigned idx_bits,
                                         input int unsigned tag_bits);
    return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/otter_sat_ctr.sv
// Saturating up/down counter next-value logic.
// Ports:
//   ctr_i  current counter value
//   up_i   1 = count up, 0 = count down
//   ctr_o  next value, clamped at 0 and at all-ones
module otter_sat_ctr #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] ctr_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != '1) ctr_o = ctr_i + WIDTH'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - WIDTH'(1);
    end
  end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB plus bimodal counter predictor for the Otter pipeline.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   PCF                       fetch PC; PredTakenF/PredTargetF are its
//                             zero-latency prediction
//   PCE, PCPlus4E, BranchE, JumpE, JalrE, TakenE, TargetE
//                             E-stage resolution used for training
//   PredTakenE, PredTargetE   prediction carried from F to E
//   StallE                    E holds; no training, counting or mispredict
//   MispredictE, RedirectPCE  flush request and correct next PC
//   BranchCount, MispredictCount  saturating performance counters
module otter_branch_predictor
  import otter_bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned XLEN     = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  input  logic            StallE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredictCount
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

  bp_entry_t tbl_q [ENTRIES];
  logic [31:0] br_cnt_q, mis_cnt_q;

  // Fetch-side lookup
  logic [IDX-1:0]        idx_f;
  logic [BP_TAG_MAX-1:0] tag_f;
  logic                  hit_f;

  assign idx_f = IDX'(bp_index(64'(PCF), IDX));
  assign tag_f = BP_TAG_MAX'(bp_tag(64'(PCF), IDX, TAG_BITS));
  assign hit_f = tbl_q[idx_f].valid && (tbl_q[idx_f].tag == tag_f);

  assign PredTakenF  = !RST && hit_f && tbl_q[idx_f].ctr[CTR_BITS-1];
  assign PredTargetF = PredTakenF ? {tbl_q[idx_f].target[XLEN-3:0], 2'b00}
                                  : PCF + XLEN'(4);

  // E-stage resolution
  logic is_ctrl, actual_taken, mis_raw;

  assign is_ctrl      = BranchE || JumpE;
  assign actual_taken = (BranchE && TakenE) || JumpE;
  assign mis_raw      = is_ctrl ? ((actual_taken != PredTakenE) ||
                                   (actual_taken && (PredTargetE != TargetE)))
                                : PredTakenE;
  assign MispredictE  = mis_raw && !StallE && !RST;
  assign RedirectPCE  = actual_taken ? TargetE : PCPlus4E;

  // Training
  logic [IDX-1:0]        idx_e;
  logic [BP_TAG_MAX-1:0] tag_e;
  logic [BP_TGT_MAX-1:0] tgt_e;
  logic                  hit_e, train;
  logic [CTR_BITS-1:0]   ctr_nxt;
  logic                  wr_en_d;
  bp_entry_t             wr_entry_d;

  assign idx_e = IDX'(bp_index(64'(PCE), IDX));
  assign tag_e = BP_TAG_MAX'(bp_tag(64'(PCE), IDX, TAG_BITS));
  assign tgt_e = BP_TGT_MAX'(TargetE[XLEN-1:2]);
  assign hit_e = tbl_q[idx_e].valid && (tbl_q[idx_e].tag == tag_e);
  assign train = !StallE && is_ctrl && !RST;

  otter_sat_ctr #(.WIDTH(CTR_BITS)) u_sat_ctr (
    .ctr_i (tbl_q[idx_e].ctr[CTR_BITS-1:0]),
    .up_i  (TakenE),
    .ctr_o (ctr_nxt)
  );

  always_comb begin
    wr_en_d    = 1'b0;
    wr_entry_d = tbl_q[idx_e];
    if (train) begin
      if (JumpE) begin
        // JALR targets are register-dependent, so only JAL is cached.
        if (!JalrE) begin
          wr_en_d           = 1'b1;
          wr_entry_d.valid  = 1'b1;
          wr_entry_d.tag    = tag_e;
          wr_entry_d.target = tgt_e;
          wr_entry_d.ctr    = BP_CTR_MAX'({CTR_BITS{1'b1}});
        end
      end else if (hit_e) begin
        wr_en_d        = 1'b1;
        wr_entry_d.ctr = BP_CTR_MAX'(ctr_nxt);
        if (TakenE) wr_entry_d.target = tgt_e;
      end else if (TakenE) begin
        wr_en_d           = 1'b1;
        wr_entry_d.valid  = 1'b1;
        wr_entry_d.tag    = tag_e;
        wr_entry_d.target = tgt_e;
        wr_entry_d.ctr    = BP_CTR_MAX'(CTR_T);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
        tbl_q[i].ctr   <= BP_CTR_MAX'(CTR_NT);
      end
    end else if (wr_en_d) begin
      tbl_q[idx_e] <= wr_entry_d;
    end
  end

  // Performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (!StallE && is_ctrl && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
      if (MispredictE && (mis_cnt_q != '1))       mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign BranchCount     = br_cnt_q;
  assign MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_otter_branch_predictor.sv
module tb_otter_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PCF, PCE, PCPlus4E, TargetE, PredTargetE;
  logic        BranchE, JumpE, JalrE, TakenE, PredTakenE, StallE;
  logic        PredTakenF, MispredictE;
  logic [31:0] PredTargetF, RedirectPCE, BranchCount, MispredictCount;

  otter_branch_predictor #(
    .ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2), .XLEN(32)
  ) dut (
    .CLK(CLK), .RST(RST), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .TakenE(TakenE),
    .TargetE(TargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .StallE(StallE), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  always #5 CLK = ~CLK;

  typedef enum int { K_PT, K_PTGT, K_MIS, K_RED, K_BC, K_MC } kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    int          step;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int failures = 0;
  int step_no = 0;

  function automatic string kname(input kind_t k);
    case (k)
      K_PT:    return "PredTakenF";
      K_PTGT:  return "PredTargetF";
      K_MIS:   return "MispredictE";
      K_RED:   return "RedirectPCE";
      K_BC:    return "BranchCount";
      default: return "MispredictCount";
    endcase
  endfunction

  function automatic logic [31:0] actual(input kind_t k);
    case (k)
      K_PT:    return {31'd0, PredTakenF};
      K_PTGT:  return PredTargetF;
      K_MIS:   return {31'd0, MispredictE};
      K_RED:   return RedirectPCE;
      K_BC:    return BranchCount;
      default: return MispredictCount;
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, so drain expectations on negedge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      item_t it;
      logic [31:0] a;
      it = sb.pop_front();
      a = actual(it.kind);
      checks++;
      if (a !== it.exp) begin
        failures++;
        $display("FAIL step%0d %s actual=0x%08h expected=0x%08h",
                 it.step, kname(it.kind), a, it.exp);
      end
    end
  end

  task automatic expect_v(input kind_t k, input logic [31:0] v);
    item_t it;
    it.kind = k; it.exp = v; it.step = step_no;
    sb.push_back(it);
  endtask

  task automatic idle_e();
    PCE = 32'h50; PCPlus4E = 32'h54; BranchE = 0; JumpE = 0; JalrE = 0;
    TakenE = 0; TargetE = 32'h0; PredTakenE = 0; PredTargetE = 32'h54;
    StallE = 0;
  endtask

  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptgt);
    PCE = pc; PCPlus4E = pc + 32'd4; BranchE = 1; JumpE = 0; JalrE = 0;
    TakenE = tk; TargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt; StallE = 0;
  endtask

  task automatic jmp(input logic [31:0] pc, input logic jalr, input logic [31:0] tgt);
    PCE = pc; PCPlus4E = pc + 32'd4; BranchE = 0; JumpE = 1; JalrE = jalr;
    TakenE = 1; TargetE = tgt; PredTakenE = 0; PredTargetE = pc + 32'd4; StallE = 0;
  endtask

  task automatic pred(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    PCF = pc;
    expect_v(K_PT, {31'd0, tk});
    expect_v(K_PTGT, tgt);
  endtask

  task automatic cnts(input int bc, input int mc);
    expect_v(K_BC, bc);
    expect_v(K_MC, mc);
  endtask

  task automatic e_out(input logic mis, input logic [31:0] red);
    expect_v(K_MIS, {31'd0, mis});
    expect_v(K_RED, red);
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge CLK);
    @(posedge CLK);
    #1;
    step_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1; PCF = 32'h100; idle_e();
    @(posedge CLK); #1;
    // Still in reset: table and counters already cleared
    pred(32'h100, 0, 32'h104); cnts(0, 0); e_out(0, 32'h54);
    cyc(); RST = 0;

    // Step 1: out of reset; then JALR resolved at 0x200
    pred(32'h200, 0, 32'h204); cnts(0, 0);
    jmp(32'h200, 1, 32'h300); e_out(1, 32'h300);
    cyc(); idle_e();
    pred(32'h200, 0, 32'h204); cnts(1, 1); e_out(0, 32'h54);
    cyc();
    // Taken branch at 0x100, first seen; same-cycle lookup sees old (miss)
    br(32'h100, 1, 32'h80, 0, 32'h104); e_out(1, 32'h80);
    pred(32'h100, 0, 32'h104);
    cyc(); idle_e();
    pred(32'h100, 1, 32'h80); cnts(2, 2);
    cyc();
    // Not-taken x3: ctr 2->1->0->0
    br(32'h100, 0, 32'h80, 1, 32'h80); e_out(1, 32'h104);
    pred(32'h100, 1, 32'h80);
    cyc();
    br(32'h100, 0, 32'h80, 0, 32'h104); e_out(0, 32'h104);
    pred(32'h100, 0, 32'h104); cnts(3, 3);
    cyc();
    br(32'h100, 0, 32'h80, 0, 32'h104); e_out(0, 32'h104);
    pred(32'h100, 0, 32'h104); cnts(4, 3);
    cyc();
    // Taken from saturated-low: 0->1, still predicts not-taken
    br(32'h100, 1, 32'h80, 0, 32'h104); e_out(1, 32'h80);
    pred(32'h100, 0, 32'h104); cnts(5, 3);
    cyc();
    // Taken with new target: 1->2, target rewritten
    br(32'h100, 1, 32'h90, 0, 32'h104); e_out(1, 32'h90);
    pred(32'h100, 0, 32'h104); cnts(6, 4);
    cyc();
    // Stalled resolution: no mispredict, no training, no counting
    br(32'h100, 0, 32'h90, 1, 32'h90); StallE = 1; e_out(0, 32'h104);
    pred(32'h100, 1, 32'h90); cnts(7, 5);
    cyc();
    // Alias 0x200 (same index, other tag): misses, then overwrites on taken
    br(32'h200, 1, 32'h400, 0, 32'h204); e_out(1, 32'h400);
    pred(32'h200, 0, 32'h204); cnts(7, 5);
    cyc();
    // Taken predicted with wrong target
    br(32'h104, 1, 32'h600, 1, 32'h500); e_out(1, 32'h600);
    pred(32'h100, 0, 32'h104); cnts(8, 6);
    cyc();
    // Correct taken prediction (target matches) allocates without mispredict
    br(32'h108, 1, 32'h700, 1, 32'h700); e_out(0, 32'h700);
    pred(32'h200, 1, 32'h400); cnts(9, 7);
    cyc();
    // Non-control instruction carrying a taken prediction
    idle_e(); PCE = 32'h10; PCPlus4E = 32'h14; PredTakenE = 1; PredTargetE = 32'h99;
    e_out(1, 32'h14);
    pred(32'h104, 1, 32'h600); cnts(10, 7);
    cyc();
    // JAL at 0x10c allocates strongly taken
    jmp(32'h10c, 0, 32'h800); e_out(1, 32'h800);
    pred(32'h108, 1, 32'h700); cnts(10, 8);
    cyc(); idle_e();
    pred(32'h10c, 1, 32'h800); cnts(11, 9);
    cyc();
    // Reset with a training event in the same cycle
    RST = 1; br(32'h110, 1, 32'h900, 0, 32'h114); e_out(0, 32'h900);
    pred(32'h10c, 0, 32'h110); cnts(11, 9);
    cyc(); RST = 0; idle_e();
    pred(32'h10c, 0, 32'h110); cnts(0, 0);
    cyc();
    pred(32'h110, 0, 32'h114);
    cyc();
    pred(32'h200, 0, 32'h204);
    @(negedge CLK); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
